// File: rtl/opcodes.sv
// rtl/opcodes.sv - shared alu opcodes, flag indices and multiply-sequencer types
package opcodes;

    localparam int unsigned FLAGS_Z = 0;
    localparam int unsigned FLAGS_N = 1;
    localparam int unsigned FLAGS_C = 2;
    localparam int unsigned FLAGS_V = 3;

    typedef enum logic [3:0] {
        FnA   = 4'h0,
        FnB   = 4'h1,
        FnADD = 4'h2,
        FnSUB = 4'h3,
        FnAND = 4'h4,
        FnOR  = 4'h5,
        FnXOR = 4'h6,
        FnNOT = 4'h7
    } alu_functions_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } alu_mseq_state_t;

    localparam int unsigned MUL_STEPS = 16;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - 16x16 shift-add multiplier borrowing the shared alu one step per grant
module alu_mul_seq
    import opcodes::*;
#(
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Start,
    input  logic [15:0]    OpA,
    input  logic [15:0]    OpB,
    output logic           Busy,
    output logic           Done,
    output logic           Err,
    output logic [15:0]    ProdHi,
    output logic [15:0]    ProdLo,
    output logic           AluReq,
    input  logic           AluGnt,
    output alu_functions_t AluOp,
    output logic [15:0]    AluOp1,
    output logic [15:0]    AluOp2,
    output logic           AluCarryIn,
    input  logic [15:0]    AluResult,
    input  logic [3:0]     AluFlags
);

    localparam int unsigned SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
    localparam logic [3:0]    COUNT_LAST = 4'(MUL_STEPS - 1);

    alu_mseq_state_t state_q, state_d;
    logic [15:0]     hi_q, hi_d;
    logic [15:0]     lo_q, lo_d;
    logic [15:0]     mcand_q, mcand_d;
    logic [3:0]      count_q, count_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            alu_flags_unused;

    assign alu_flags_unused = ^AluFlags;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        count_d = count_q;
        stall_d = stall_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    mcand_d = OpA;
                    hi_d    = 16'h0000;
                    lo_d    = OpB;
                    count_d = 4'd0;
                    stall_d = '0;
                    state_d = STEP;
                end
            end
            STEP: begin
                if (AluGnt) begin
                    // Carry out of the add becomes the new top bit as the pair shifts right.
                    {hi_d, lo_d} = {AluFlags[FLAGS_C], AluResult, lo_q[15:1]};
                    count_d      = count_q + 4'd1;
                    stall_d      = '0;
                    if (count_q == COUNT_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    stall_d = stall_q + 1'b1;
                    if ((STALL_LIMIT != 0) && (stall_q == STALL_LAST)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        hi_d    = 16'h0000;
                        lo_d    = 16'h0000;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == STEP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            hi_q    <= 16'h0000;
            lo_q    <= 16'h0000;
            mcand_q <= 16'h0000;
            count_q <= 4'd0;
            stall_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Alu-facing signals follow the current state so the external mux sees them in the grant cycle.
    always_comb begin
        AluReq     = (state_q == STEP);
        AluOp      = (state_q == STEP) ? FnADD : FnA;
        AluOp1     = (state_q == STEP) ? hi_q : 16'h0000;
        AluOp2     = ((state_q == STEP) && lo_q[0]) ? mcand_q : 16'h0000;
        AluCarryIn = 1'b0;
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Err    = err_q;
    assign ProdHi = hi_q;
    assign ProdLo = lo_q;

endmodule
